// File: rtl/ctrl_pipe_hz.sv
// ctrl_pipe_hz: MIPS pipeline controller with integrated hazard unit.
// Decodes in D, carries control through E, M1..Mk, W; drives stall/flush/forward.
// Ports: CLK, Reset (async, active-low); D fields OpD/FunctD/RsD/RtD/RdD/EqualD;
// MemReadyM; D decode outs; StallF/StallD/FlushD/FlushE; E ALU ctl + forwards;
// Mk memory controls; W writeback controls.
module ctrl_pipe_hz #(
    parameter int MEM_STAGES = 1,
    parameter int REG_AW     = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [5:0]        OpD,
    input  logic [5:0]        FunctD,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RdD,
    input  logic              EqualD,
    input  logic              MemReadyM,
    output logic              BranchD,
    output logic              JumpD,
    output logic              ExtOpD,
    output logic              PCSrcD,
    output logic              IllegalD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              ALUSrcE,
    output logic [2:0]        ALUCtlE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MemWriteM,
    output logic              DEnM,
    output logic [REG_AW-1:0] WriteRegE,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              MemToRegW,
    output logic              RegWriteW
);
    localparam int K = MEM_STAGES;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              alu_src;
        logic [2:0]        alu_ctl;
        logic [REG_AW-1:0] write_reg;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ex_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic [REG_AW-1:0] write_reg;
    } mem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] write_reg;
    } wb_t;

    ex_t          d_ctl;
    logic         ill_d;
    logic         bne_d;
    logic         use_rs_d;
    logic         use_rt_d;
    logic         hz;
    ex_t          e_q, e_d;
    mem_t [K-1:0] m_q, m_d;
    wb_t          w_q, w_d;

    function automatic logic hit(
        input logic              rw,
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              urs,
        input logic              urt
    );
        return rw && (dst != '0) &&
               ((urs && dst == rs) || (urt && dst == rt));
    endfunction

    always_comb begin
        d_ctl           = '0;
        d_ctl.rs        = RsD;
        d_ctl.rt        = RtD;
        d_ctl.write_reg = RtD;
        d_ctl.alu_ctl   = 3'b010;
        BranchD  = 1'b0;
        JumpD    = 1'b0;
        ExtOpD   = 1'b0;
        ill_d    = 1'b0;
        bne_d    = 1'b0;
        use_rs_d = 1'b1;
        use_rt_d = 1'b0;
        case (OpD)
            6'b000000: begin
                d_ctl.write_reg = RdD;
                d_ctl.reg_write = 1'b1;
                use_rt_d        = 1'b1;
                case (FunctD)
                    6'b100000: d_ctl.alu_ctl = 3'b010;
                    6'b100010: d_ctl.alu_ctl = 3'b110;
                    6'b100100: d_ctl.alu_ctl = 3'b000;
                    6'b100101: d_ctl.alu_ctl = 3'b001;
                    6'b101010: d_ctl.alu_ctl = 3'b111;
                    default:   ill_d = 1'b1;
                endcase
            end
            6'b100011: begin
                d_ctl.reg_write  = 1'b1;
                d_ctl.mem_to_reg = 1'b1;
                d_ctl.alu_src    = 1'b1;
                ExtOpD           = 1'b1;
            end
            6'b101011: begin
                d_ctl.mem_write = 1'b1;
                d_ctl.alu_src   = 1'b1;
                ExtOpD          = 1'b1;
                use_rt_d        = 1'b1;
            end
            6'b000100, 6'b000101: begin
                BranchD       = 1'b1;
                bne_d         = OpD[0];
                ExtOpD        = 1'b1;
                d_ctl.alu_ctl = 3'b110;
                use_rt_d      = 1'b1;
            end
            6'b001000: begin
                d_ctl.reg_write = 1'b1;
                d_ctl.alu_src   = 1'b1;
                ExtOpD          = 1'b1;
            end
            6'b001100, 6'b001101: begin
                d_ctl.reg_write = 1'b1;
                d_ctl.alu_src   = 1'b1;
                d_ctl.alu_ctl   = {2'b00, OpD[0]};
            end
            6'b000010: begin
                JumpD    = 1'b1;
                use_rs_d = 1'b0;
            end
            default: ill_d = 1'b1;
        endcase
        // Unsupported encodings travel as a bubble and read nothing.
        if (ill_d) begin
            d_ctl    = '0;
            use_rs_d = 1'b0;
            use_rt_d = 1'b0;
        end
    end

    assign IllegalD = ill_d;

    // Loads stall until they reach Mk; ALU results stall until M1 is the
    // last memory stage; branches compare in D so wait out E..Mk.
    always_comb begin
        hz = 1'b0;
        if (hit(e_q.reg_write, e_q.write_reg, RsD, RtD, use_rs_d, use_rt_d)
            && (e_q.mem_to_reg || BranchD))
            hz = 1'b1;
        for (int i = 0; i < K; i++) begin
            if (hit(m_q[i].reg_write, m_q[i].write_reg,
                    RsD, RtD, use_rs_d, use_rt_d)
                && (BranchD || i < K - 1))
                hz = 1'b1;
        end
    end

    assign StallD = hz | ~MemReadyM;
    assign StallF = StallD;
    assign FlushE = hz & MemReadyM;
    assign PCSrcD = BranchD & (bne_d ^ EqualD) & ~StallD;
    assign FlushD = (PCSrcD | JumpD) & ~StallD;

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (MemReadyM) begin
            e_d                 = hz ? '0 : d_ctl;
            m_d[0].reg_write    = e_q.reg_write;
            m_d[0].mem_to_reg   = e_q.mem_to_reg;
            m_d[0].mem_write    = e_q.mem_write;
            m_d[0].write_reg    = e_q.write_reg;
            for (int i = 1; i < K; i++)
                m_d[i] = m_q[i-1];
            w_d.reg_write  = m_q[K-1].reg_write;
            w_d.mem_to_reg = m_q[K-1].mem_to_reg;
            w_d.write_reg  = m_q[K-1].write_reg;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // M1 forwarding only for ALU results; load data is not ready in M1.
    logic m1_ok;
    logic w_ok;
    assign m1_ok = m_q[0].reg_write & ~m_q[0].mem_to_reg
                 & (m_q[0].write_reg != '0);
    assign w_ok  = w_q.reg_write & (w_q.write_reg != '0);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (m1_ok && m_q[0].write_reg == e_q.rs)
            ForwardAE = 2'b10;
        else if (w_ok && w_q.write_reg == e_q.rs)
            ForwardAE = 2'b01;
        if (m1_ok && m_q[0].write_reg == e_q.rt)
            ForwardBE = 2'b10;
        else if (w_ok && w_q.write_reg == e_q.rt)
            ForwardBE = 2'b01;
    end

    assign ALUSrcE   = e_q.alu_src;
    assign ALUCtlE   = e_q.alu_ctl;
    assign WriteRegE = e_q.write_reg;
    assign MemWriteM = m_q[K-1].mem_write;
    assign DEnM      = m_q[K-1].mem_to_reg | m_q[K-1].mem_write;
    assign WriteRegW = w_q.write_reg;
    assign MemToRegW = w_q.mem_to_reg;
    assign RegWriteW = w_q.reg_write;
endmodule

// File: tb/tb_ctrl_pipe_hz.sv
// tb_ctrl_pipe_hz: directed bench for ctrl_pipe_hz, MEM_STAGES=1 and 3.
// Expectations are queued by stimulus and compared by a negedge monitor.
module tb_ctrl_pipe_hz;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       eq, mrdy;

    logic [1:0] br, jp, ext, pcs, ill, stf, std, fld, fle;
    logic [1:0] alus, memw, den, m2r, rw;
    logic [2:0] aluc [2];
    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic [4:0] wre [2];
    logic [4:0] wrw [2];

    always #5 clk = ~clk;

    ctrl_pipe_hz #(.MEM_STAGES(1), .REG_AW(5)) u1 (
        .CLK(clk), .Reset(rst_n), .OpD(op), .FunctD(fn),
        .RsD(rs), .RtD(rt), .RdD(rd), .EqualD(eq), .MemReadyM(mrdy),
        .BranchD(br[0]), .JumpD(jp[0]), .ExtOpD(ext[0]), .PCSrcD(pcs[0]),
        .IllegalD(ill[0]), .StallF(stf[0]), .StallD(std[0]),
        .FlushD(fld[0]), .FlushE(fle[0]), .ALUSrcE(alus[0]),
        .ALUCtlE(aluc[0]), .ForwardAE(fa[0]), .ForwardBE(fb[0]),
        .MemWriteM(memw[0]), .DEnM(den[0]), .WriteRegE(wre[0]),
        .WriteRegW(wrw[0]), .MemToRegW(m2r[0]), .RegWriteW(rw[0])
    );

    ctrl_pipe_hz #(.MEM_STAGES(3), .REG_AW(5)) u3 (
        .CLK(clk), .Reset(rst_n), .OpD(op), .FunctD(fn),
        .RsD(rs), .RtD(rt), .RdD(rd), .EqualD(eq), .MemReadyM(mrdy),
        .BranchD(br[1]), .JumpD(jp[1]), .ExtOpD(ext[1]), .PCSrcD(pcs[1]),
        .IllegalD(ill[1]), .StallF(stf[1]), .StallD(std[1]),
        .FlushD(fld[1]), .FlushE(fle[1]), .ALUSrcE(alus[1]),
        .ALUCtlE(aluc[1]), .ForwardAE(fa[1]), .ForwardBE(fb[1]),
        .MemWriteM(memw[1]), .DEnM(den[1]), .WriteRegE(wre[1]),
        .WriteRegW(wrw[1]), .MemToRegW(m2r[1]), .RegWriteW(rw[1])
    );

    localparam int STF = 0, STD = 1, FLD = 2, FLE = 3, PCS = 4;
    localparam int BR = 5, JP = 6, EXT = 7, ILL = 8, ALUS = 9;
    localparam int ALUC = 10, FA = 11, FB = 12, MEMW = 13, DEN = 14;
    localparam int WRE = 15, WRW = 16, M2R = 17, RW = 18, NSIG = 19;

    typedef struct {
        int    cyc;
        int    dut;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get(input int d, input int s);
        case (s)
            STF:  return int'(stf[d]);
            STD:  return int'(std[d]);
            FLD:  return int'(fld[d]);
            FLE:  return int'(fle[d]);
            PCS:  return int'(pcs[d]);
            BR:   return int'(br[d]);
            JP:   return int'(jp[d]);
            EXT:  return int'(ext[d]);
            ILL:  return int'(ill[d]);
            ALUS: return int'(alus[d]);
            ALUC: return int'(aluc[d]);
            FA:   return int'(fa[d]);
            FB:   return int'(fb[d]);
            MEMW: return int'(memw[d]);
            DEN:  return int'(den[d]);
            WRE:  return int'(wre[d]);
            WRW:  return int'(wrw[d]);
            M2R:  return int'(m2r[d]);
            RW:   return int'(rw[d]);
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   a;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            a = get(e.dut, e.sig);
            checks++;
            if (a != e.val) begin
                failures++;
                $display("FAIL %s: got %0d want %0d (cycle %0d)",
                         e.name, a, e.val, cyc);
            end
        end
    end

    task automatic expv(input int d, input int s, input int v,
                        input string n);
        exp_t e;
        e.cyc = cyc; e.dut = d; e.sig = s; e.val = v; e.name = n;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d);
        op = 6'b000000; fn = f; rs = s; rt = t; rd = d;
    endtask

    task automatic itype(input logic [5:0] o, input logic [4:0] s,
                         input logic [4:0] t);
        op = o; fn = 6'b000000; rs = s; rt = t; rd = 5'd0;
    endtask

    task automatic nop();
        rtype(6'b100000, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; nop(); eq = 1'b0; mrdy = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010;
    localparam logic [5:0] OR_ = 6'b100101;
    localparam logic [5:0] LW = 6'b100011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100, J = 6'b000010;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop(); eq = 1'b0; mrdy = 1'b1;
        tick();
        do_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < NSIG; s++)
                expv(d, s, 0, $sformatf("rst_d%0d_s%0d", d, s));
        tick();

        // add r3 ; sub r4,r3 back-to-back (k=1)
        do_reset();
        rtype(ADD, 5'd1, 5'd2, 5'd3);
        tick();
        rtype(SUB, 5'd3, 5'd1, 5'd4);
        expv(0, STD, 0, "t1_nostall");
        tick();
        nop();
        expv(0, FA, 2, "t1_fa");
        expv(0, FB, 0, "t1_fb");
        expv(0, ALUC, 6, "t1_aluc");
        expv(0, WRE, 4, "t1_wre");
        tick();

        // lw r2 ; add r5,r2,r1 (k=1)
        do_reset();
        itype(LW, 5'd1, 5'd2);
        tick();
        rtype(ADD, 5'd2, 5'd1, 5'd5);
        expv(0, STD, 1, "t2_std");
        expv(0, STF, 1, "t2_stf");
        expv(0, FLE, 1, "t2_fle");
        expv(0, FLD, 0, "t2_fld");
        tick();
        expv(0, STD, 0, "t2_std_rel");
        expv(0, FLE, 0, "t2_fle_rel");
        expv(0, WRE, 0, "t2_bubble");
        tick();
        nop();
        expv(0, FA, 1, "t2_fa");
        expv(0, FB, 0, "t2_fb");
        expv(0, WRE, 5, "t2_wre");
        expv(0, WRW, 2, "t2_wrw");
        expv(0, M2R, 1, "t2_m2r");
        tick();

        // addi r6 ; or r7,r6 back-to-back (k=3)
        do_reset();
        itype(ADDI, 5'd1, 5'd6);
        expv(1, EXT, 1, "t3a_ext");
        tick();
        rtype(OR_, 5'd6, 5'd2, 5'd7);
        expv(1, STD, 0, "t3a_nostall");
        tick();
        nop();
        expv(1, FA, 2, "t3a_fa");
        expv(1, ALUC, 1, "t3a_aluc");
        expv(1, WRE, 7, "t3a_wre");
        tick();

        // addi r6 ; nop ; or r7,r6 (k=3): two stall cycles
        do_reset();
        itype(ADDI, 5'd1, 5'd6);
        tick();
        nop();
        tick();
        rtype(OR_, 5'd6, 5'd2, 5'd7);
        expv(1, STD, 1, "t3b_std0");
        expv(1, FLE, 1, "t3b_fle0");
        tick();
        expv(1, STD, 1, "t3b_std1");
        tick();
        expv(1, STD, 0, "t3b_std2");
        tick();
        nop();
        expv(1, FA, 1, "t3b_fa");
        expv(1, WRW, 6, "t3b_wrw");
        expv(1, RW, 1, "t3b_rw");
        tick();

        // branches and jump (k=1)
        do_reset();
        itype(BEQ, 5'd1, 5'd2); eq = 1'b1;
        expv(0, BR, 1, "t4_br");
        expv(0, PCS, 1, "t4_beq_pcs");
        expv(0, FLD, 1, "t4_beq_fld");
        expv(0, STD, 0, "t4_beq_std");
        tick();
        itype(BNE, 5'd1, 5'd2);
        expv(0, PCS, 0, "t4_bne_eq_pcs");
        expv(0, FLD, 0, "t4_bne_eq_fld");
        tick();
        eq = 1'b0;
        expv(0, PCS, 1, "t4_bne_ne_pcs");
        tick();
        itype(J, 5'd0, 5'd0);
        expv(0, JP, 1, "t4_jp");
        expv(0, FLD, 1, "t4_j_fld");
        expv(0, PCS, 0, "t4_j_pcs");
        tick();
        itype(ADDI, 5'd0, 5'd1);
        tick();
        itype(BEQ, 5'd1, 5'd2); eq = 1'b1;
        expv(0, STD, 1, "t4_bhz_std");
        expv(0, PCS, 0, "t4_bhz_pcs");
        expv(0, FLD, 0, "t4_bhz_fld");
        expv(0, FLE, 1, "t4_bhz_fle");
        tick();
        expv(0, STD, 1, "t4_bhz_mk");
        tick();
        expv(0, STD, 0, "t4_bhz_w");
        expv(0, PCS, 1, "t4_bhz_w_pcs");
        tick();
        itype(ANDI, 5'd9, 5'd8); eq = 1'b0;
        expv(0, EXT, 0, "t4_andi_ext");
        expv(0, ILL, 0, "t4_andi_ill");
        tick();
        rtype(6'b000000, 5'd1, 5'd2, 5'd3);
        expv(0, ILL, 1, "t4_badfunct");
        tick();

        // memory stall (k=1)
        do_reset();
        itype(ADDI, 5'd0, 5'd9);
        tick();
        itype(LW, 5'd1, 5'd2);
        tick();
        rtype(ADD, 5'd2, 5'd1, 5'd5); mrdy = 1'b0;
        expv(0, STD, 1, "t5_hz_mem_std");
        expv(0, FLE, 0, "t5_hz_mem_fle");
        tick();
        mrdy = 1'b1;
        expv(0, STD, 1, "t5_hz_std");
        expv(0, FLE, 1, "t5_hz_fle");
        tick();
        mrdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expv(0, DEN, 1, $sformatf("t5_den%0d", i));
            expv(0, WRW, 9, $sformatf("t5_wrw%0d", i));
            expv(0, STD, 1, $sformatf("t5_std%0d", i));
            expv(0, STF, 1, $sformatf("t5_stf%0d", i));
            expv(0, FLE, 0, $sformatf("t5_fle%0d", i));
            tick();
        end
        mrdy = 1'b1;
        expv(0, STD, 0, "t5_rel_std");
        expv(0, DEN, 1, "t5_rel_den");
        expv(0, WRW, 9, "t5_rel_wrw");
        tick();
        nop();
        expv(0, WRW, 2, "t5_wrw_lw");
        expv(0, M2R, 1, "t5_m2r");
        expv(0, DEN, 0, "t5_den_off");
        expv(0, FA, 1, "t5_fa");
        tick();

        // asynchronous reset mid-stream
        do_reset();
        itype(ADDI, 5'd0, 5'd9);
        tick();
        itype(LW, 5'd1, 5'd2);
        tick();
        rtype(ADD, 5'd6, 5'd7, 5'd5);
        tick();
        nop(); mrdy = 1'b0;
        expv(0, DEN, 1, "t6_pre_den");
        expv(0, WRW, 9, "t6_pre_wrw");
        expv(0, WRE, 5, "t6_pre_wre");
        tick();
        rst_n = 1'b0; mrdy = 1'b1;
        itype(6'b111111, 5'd0, 5'd0);
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < NSIG; s++)
                expv(d, s, (s == ILL) ? 1 : 0,
                     $sformatf("t6_d%0d_s%0d", d, s));
        tick();
        rst_n = 1'b1;
        nop();
        tick();

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d left want 0",
                     sbq.size());
            failures++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
